// File: rtl/jtag_dmi_sequencer.sv
// rtl/jtag_dmi_sequencer.sv - JTAG DTM sequencer turning DMI/DTMCS DR updates into debug-module requests (optional: JTAG_DMI_TIMEOUT_EN)
module jtag_dmi_sequencer #(
  parameter int         ADDR_W         = 7,
  parameter int         DATA_W         = 32,
  parameter logic [4:0] INSTR_DTMCS    = 5'h10,
  parameter logic [4:0] INSTR_DMI      = 5'h11,
  parameter logic [2:0] IDLE_HINT      = 3'd5,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic                       _clock_falling_T_1,
  input  logic                       io_control_jtag_reset,
  input  logic [4:0]                 instruction,
  input  logic                       dr_capture,
  input  logic                       dr_update,
  input  logic [ADDR_W+DATA_W+1:0]   dmi_update_bits,
  input  logic [31:0]                dtmcs_update_bits,
  output logic [ADDR_W+DATA_W+1:0]   dmi_capture_bits,
  output logic [31:0]                dtmcs_capture_bits,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [ADDR_W-1:0]          req_addr,
  output logic [DATA_W-1:0]          req_data,
  output logic [1:0]                 req_op,
  input  logic                       resp_valid,
  output logic                       resp_ready,
  input  logic [DATA_W-1:0]          resp_data,
  input  logic [1:0]                 resp_op,
  output logic                       busy
);

  localparam int DMI_W = ADDR_W + DATA_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              r_state;
  logic                r_req_valid;
  logic                r_resp_ready;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [DATA_W-1:0]   r_req_data;
  logic [1:0]          r_req_op;
  logic [1:0]          r_sticky;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [DATA_W-1:0]   r_last_data;
  logic [DMI_W-1:0]    r_dmi_capture;

  logic                w_dmi_update;
  logic                w_dmi_capture;
  logic                w_dtmcs_update;
  logic                w_hard_reset;
  logic                w_dmi_reset;
  logic                w_busy;
  logic [ADDR_W-1:0]   w_upd_addr;
  logic [DATA_W-1:0]   w_upd_data;
  logic [1:0]          w_upd_op;
  logic                w_violation;
  logic                w_start;
  logic                w_resp_fire;
  logic                w_timeout;
  logic [1:0]          w_sticky_next;
  logic [31:0]         w_unused_timeout;
  logic                w_unused_bits;

  assign w_dmi_update   = dr_update  && (instruction == INSTR_DMI);
  assign w_dmi_capture  = dr_capture && (instruction == INSTR_DMI);
  assign w_dtmcs_update = dr_update  && (instruction == INSTR_DTMCS);
  assign w_hard_reset   = w_dtmcs_update && dtmcs_update_bits[17];
  assign w_dmi_reset    = w_dtmcs_update && dtmcs_update_bits[16];
  assign w_busy         = (r_state != S_IDLE);

  assign w_upd_addr = dmi_update_bits[DMI_W-1 -: ADDR_W];
  assign w_upd_data = dmi_update_bits[DATA_W+1:2];
  assign w_upd_op   = dmi_update_bits[1:0];

  // Any DMI scan touching the chain while a transaction is in flight is a busy violation
  assign w_violation = w_busy && (w_dmi_update || w_dmi_capture);
  assign w_start     = !w_busy && w_dmi_update && (w_upd_op == 2'd1 || w_upd_op == 2'd2) && (r_sticky == 2'd0);
  assign w_resp_fire = (r_state == S_WAIT) && resp_valid;

  // Only bits 16/17 of DTMCS are writable; the rest, and the timeout depth in the default build, are intentionally dropped
  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_unused_bits    = ^{dtmcs_update_bits[31:18], dtmcs_update_bits[15:0], w_unused_timeout};

`ifdef JTAG_DMI_TIMEOUT_EN
  localparam int TMR_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  logic [TMR_W-1:0] r_timer;

  assign w_timeout = w_busy && !w_resp_fire && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent in REQ/WAIT since the request was launched
  always_ff @(posedge _clock_falling_T_1 or posedge io_control_jtag_reset) begin
    if (io_control_jtag_reset) begin
      r_timer <= '0;
    end else if (w_start) begin
      r_timer <= '0;
    end else if (w_busy) begin
      r_timer <= r_timer + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // First error wins: violation, then response error, then timeout; DTMCS resets override all
  always_comb begin
    w_sticky_next = r_sticky;
    if (w_violation && w_sticky_next == 2'd0) begin
      w_sticky_next = 2'd3;
    end
    if (w_resp_fire && resp_op != 2'd0 && w_sticky_next == 2'd0) begin
      w_sticky_next = resp_op;
    end
    if (w_timeout && w_sticky_next == 2'd0) begin
      w_sticky_next = 2'd2;
    end
    if (w_dmi_reset || w_hard_reset) begin
      w_sticky_next = 2'd0;
    end
  end

  // Request/response FSM with registered handshake outputs and the DMI capture register
  always_ff @(posedge _clock_falling_T_1 or posedge io_control_jtag_reset) begin
    if (io_control_jtag_reset) begin
      r_state       <= S_IDLE;
      r_req_valid   <= 1'b0;
      r_resp_ready  <= 1'b0;
      r_req_addr    <= '0;
      r_req_data    <= '0;
      r_req_op      <= '0;
      r_sticky      <= 2'd0;
      r_last_addr   <= '0;
      r_last_data   <= '0;
      r_dmi_capture <= '0;
    end else begin
      r_sticky <= w_sticky_next;
      if (w_dmi_capture) begin
        r_dmi_capture <= {r_last_addr, r_last_data, (w_busy ? 2'd3 : r_sticky)};
      end
      if (w_hard_reset) begin
        r_state      <= S_IDLE;
        r_req_valid  <= 1'b0;
        r_resp_ready <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
              r_req_addr  <= w_upd_addr;
              r_req_data  <= w_upd_data;
              r_req_op    <= w_upd_op;
              r_last_addr <= w_upd_addr;
            end
          end
          S_REQ: begin
            if (w_timeout) begin
              r_state     <= S_IDLE;
              r_req_valid <= 1'b0;
            end else if (r_req_valid && req_ready) begin
              r_state      <= S_WAIT;
              r_req_valid  <= 1'b0;
              r_resp_ready <= 1'b1;
            end
          end
          S_WAIT: begin
            if (w_resp_fire) begin
              r_last_data  <= resp_data;
              r_state      <= S_IDLE;
              r_resp_ready <= 1'b0;
            end else if (w_timeout) begin
              r_state      <= S_IDLE;
              r_resp_ready <= 1'b0;
            end
          end
          default: begin
            r_state      <= S_IDLE;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dmi_capture_bits   = r_dmi_capture;
  assign dtmcs_capture_bits = {17'd0, IDLE_HINT, r_sticky, 6'(ADDR_W), 4'd1};
  assign req_valid          = r_req_valid;
  assign req_addr           = r_req_addr;
  assign req_data           = r_req_data;
  assign req_op             = r_req_op;
  assign resp_ready         = r_resp_ready;
  assign busy               = w_busy;

endmodule

// File: tb/tb_jtag_dmi_sequencer.sv
// tb/tb_jtag_dmi_sequencer.sv - randomized self-checking bench for jtag_dmi_sequencer
module tb_jtag_dmi_sequencer;

  localparam logic [4:0] I_DTMCS = 5'h10;
  localparam logic [4:0] I_DMI   = 5'h11;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  instruction;
  logic        dr_capture, dr_update;
  logic [40:0] dmi_update_bits;
  logic [31:0] dtmcs_update_bits;
  logic [40:0] dmi_capture_bits;
  logic [31:0] dtmcs_capture_bits;
  logic        req_valid, req_ready;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_op;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0]  m_sticky;
  logic [6:0]  m_last_addr;
  logic [31:0] m_last_data;

  jtag_dmi_sequencer dut (
    ._clock_falling_T_1   (clk),
    .io_control_jtag_reset(rst),
    .instruction          (instruction),
    .dr_capture           (dr_capture),
    .dr_update            (dr_update),
    .dmi_update_bits      (dmi_update_bits),
    .dtmcs_update_bits    (dtmcs_update_bits),
    .dmi_capture_bits     (dmi_capture_bits),
    .dtmcs_capture_bits   (dtmcs_capture_bits),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_addr             (req_addr),
    .req_data             (req_data),
    .req_op               (req_op),
    .resp_valid           (resp_valid),
    .resp_ready           (resp_ready),
    .resp_data            (resp_data),
    .resp_op              (resp_op),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_dtmcs(input logic [1:0] s);
    return {17'd0, 3'd5, s, 6'd7, 4'd1};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    instruction = I_DMI;
    dr_capture  = 1'b1;
    tick();
    dr_capture  = 1'b0;
    check({tag, "_dmi_cap"}, 64'(dmi_capture_bits), 64'({m_last_addr, m_last_data, m_sticky}));
    check({tag, "_dtmcs"}, 64'(dtmcs_capture_bits), 64'(exp_dtmcs(m_sticky)));
  endtask

  task automatic dmi_reset();
    instruction       = I_DTMCS;
    dtmcs_update_bits = 32'h0001_0000;
    dr_update         = 1'b1;
    tick();
    dr_update = 1'b0;
    m_sticky  = 2'd0;
    check("dmireset_dtmcs", 64'(dtmcs_capture_bits), 64'(exp_dtmcs(2'd0)));
  endtask

  task automatic dmi_update(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
    instruction     = I_DMI;
    dmi_update_bits = {addr, data, op};
    dr_update       = 1'b1;
    tick();
    dr_update = 1'b0;
  endtask

  // viol: 0 none, 1 extra DMI update while in REQ, 2 DMI capture coinciding with the response
  task automatic dmi_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                         input int ready_wait, input int resp_wait, input logic [1:0] rop,
                         input logic [31:0] rdata, input int viol);
    bit issue;
    issue = (op == 2'd1 || op == 2'd2) && (m_sticky == 2'd0);
    dmi_update(op, addr, data);
    if (!issue) begin
      check("noreq_valid", 64'(req_valid), 64'd0);
      check("noreq_busy", 64'(busy), 64'd0);
      resp_valid = 1'b1;
      resp_op    = 2'd2;
      resp_data  = $urandom;
      tick();
      resp_valid = 1'b0;
      check("noreq_valid2", 64'(req_valid), 64'd0);
    end else begin
      m_last_addr = addr;
      check("req_valid", 64'(req_valid), 64'd1);
      check("req_payload", 64'({req_addr, req_data, req_op}), 64'({addr, data, op}));
      check("req_busy", 64'(busy), 64'd1);
      for (int i = 0; i < ready_wait; i++) tick();
      if (viol == 1) begin
        dmi_update(2'd1, 7'h7f, 32'hffff_ffff);
        if (m_sticky == 2'd0) m_sticky = 2'd3;
      end
      check("req_hold_valid", 64'(req_valid), 64'd1);
      check("req_hold_payload", 64'({req_addr, req_data, req_op}), 64'({addr, data, op}));
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      check("hs_req_valid", 64'(req_valid), 64'd0);
      check("hs_resp_ready", 64'(resp_ready), 64'd1);
      for (int i = 0; i < resp_wait; i++) tick();
      resp_valid = 1'b1;
      resp_op    = rop;
      resp_data  = rdata;
      if (viol == 2) begin
        instruction = I_DMI;
        dr_capture  = 1'b1;
      end
      tick();
      resp_valid = 1'b0;
      dr_capture = 1'b0;
      if (viol == 2) begin
        check("busy_capture", 64'(dmi_capture_bits), 64'({m_last_addr, m_last_data, 2'd3}));
        if (m_sticky == 2'd0) m_sticky = 2'd3;
      end
      m_last_data = rdata;
      if (rop != 2'd0 && m_sticky == 2'd0) m_sticky = rop;
      check("done_busy", 64'(busy), 64'd0);
      check("done_resp_ready", 64'(resp_ready), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    instruction = 5'd0; dr_capture = 1'b0; dr_update = 1'b0;
    dmi_update_bits = '0; dtmcs_update_bits = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; resp_op = '0;
    m_sticky = 2'd0; m_last_addr = '0; m_last_data = '0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_resp_ready", 64'(resp_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dmi_cap", 64'(dmi_capture_bits), 64'd0);
    check("rst_dtmcs", 64'(dtmcs_capture_bits), 64'h5071);
    rst = 1'b0;
    tick();

    dmi_txn(2'd2, 7'h10, 32'h1, 0, 0, 2'd0, 32'h1, 0);
    check_status("write");
    dmi_txn(2'd1, 7'h11, 32'h0, 0, 0, 2'd0, 32'hdead_beef, 0);
    check_status("read");

    dmi_txn(2'd2, 7'h12, 32'h5, 3, 0, 2'd0, 32'h55, 1);
    check_status("viol");
    dmi_txn(2'd1, 7'h20, 32'h0, 0, 0, 2'd0, 32'h0, 0);
    dmi_reset();
    check_status("viol_clr");

    dmi_txn(2'd1, 7'h13, 32'h0, 1, 1, 2'd2, 32'h1234_5678, 2);
    check_status("resp_and_viol");
    dmi_reset();

    dmi_txn(2'd1, 7'h14, 32'h0, 0, 0, 2'd2, 32'h0bad_f00d, 0);
    check_status("failed");
    dmi_txn(2'd1, 7'h21, 32'h0, 0, 0, 2'd0, 32'h0, 0);
    dmi_reset();

    dmi_update(2'd1, 7'h15, 32'h0);
    m_last_addr = 7'h15;
    dmi_update(2'd1, 7'h16, 32'h0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("hard_pre_wait", 64'(resp_ready), 64'd1);
    instruction       = I_DTMCS;
    dtmcs_update_bits = 32'h0002_0000;
    dr_update         = 1'b1;
    tick();
    dr_update = 1'b0;
    m_sticky  = 2'd0;
    check("hard_busy", 64'(busy), 64'd0);
    check("hard_resp_ready", 64'(resp_ready), 64'd0);
    resp_valid = 1'b1; resp_op = 2'd0; resp_data = 32'hbad0_bad0;
    tick();
    resp_valid = 1'b0;
    check_status("hard");

    dmi_update(2'd2, 7'h17, 32'h9);
    check("arst_pre_valid", 64'(req_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req_valid", 64'(req_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_sticky = 2'd0; m_last_addr = '0; m_last_data = '0;
    tick();
    check_status("arst");

`ifdef JTAG_DMI_TIMEOUT_EN
    dmi_update(2'd1, 7'h18, 32'h0);
    m_last_addr = 7'h18;
    repeat (255) tick();
    check("to_busy_before", 64'(busy), 64'd1);
    tick();
    check("to_busy_after", 64'(busy), 64'd0);
    check("to_req_valid", 64'(req_valid), 64'd0);
    m_sticky = 2'd2;
    resp_valid = 1'b1; resp_op = 2'd0; resp_data = 32'h7777_7777;
    tick();
    resp_valid = 1'b0;
    check_status("timeout");
    dmi_reset();
`endif

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) < 2) begin
        dmi_reset();
      end else begin
        logic [1:0] rop;
        case ($urandom_range(0, 4))
          3:       rop = 2'd2;
          4:       rop = 2'd3;
          default: rop = 2'd0;
        endcase
        dmi_txn(2'($urandom_range(0, 3)), 7'($urandom), $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rop, $urandom,
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0);
        check_status("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
